// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//   Lets up to NREQ requesters share one status LED. Each requester asks for
//   a burst of blinks. Requesters are granted one at a time in round-robin
//   order. The granted burst then runs the LED through timed on/off phases.
//
//   Optional feature macro: BLINK_ARB_GAP_EN
//     defined   : each burst ends with a PHASE-cycle dark gap before done
//     undefined : the last off phase goes straight back to idle
//
//   Ports
//     clk    in   rising-edge clock
//     rst    in   synchronous, active-high reset
//     req    in   [NREQ]        level request, one bit per requester
//     count  in   [NREQ*NBITS]  blink count, requester i at [i*NBITS +: NBITS]
//     grant  out  [NREQ]        one-hot, one-cycle pulse when a burst starts
//     owner  out  [NREQ]        one-hot owner of the running burst, 0 when idle
//     busy   out                high while a burst is in progress
//     led    out                LED drive
//     done   out                one-cycle pulse when a burst completes
module led_blink_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 4,
  parameter int CBITS = 12,
  parameter int PHASE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*NBITS-1:0]  count,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        owner,
  output logic                   busy,
  output logic                   led,
  output logic                   done
);

  localparam int unsigned NR = NREQ;
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] PH_LAST  = CBITS'(PHASE - 1);
  localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
  localparam logic [NBITS-1:0] REM_ONE  = NBITS'(1);
  localparam logic [LW-1:0]    LAST_RST = LW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
`ifdef BLINK_ARB_GAP_EN
    , S_GAP
`endif
  } state_e;

  state_e            state_q;
  logic [CBITS-1:0]  cnt_q;
  logic [NBITS-1:0]  rem_q;
  logic [LW-1:0]     last_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   owner_q;
  logic              busy_q;
  logic              led_q;
  logic              done_q;

  // Round-robin pick: requests strictly above the last grant win first;
  // if there are none, the lowest set request wraps around.
  logic [NREQ-1:0]   hi_mask;
  logic [NREQ-1:0]   req_hi;
  logic [NREQ-1:0]   src;
  logic              found;
  logic [LW-1:0]     pick_idx_d;
  logic [NREQ-1:0]   pick_oh_d;
  logic [NBITS-1:0]  pick_cnt;
  logic [NBITS-1:0]  rem_d;

  always_comb begin
    hi_mask    = '0;
    found      = 1'b0;
    pick_idx_d = '0;
    pick_oh_d  = '0;
    pick_cnt   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      hi_mask[i] = (i[LW-1:0] > last_q);
    end
    req_hi = req & hi_mask;
    src    = (req_hi != '0) ? req_hi : req;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!found && src[i]) begin
        found        = 1'b1;
        pick_idx_d   = i[LW-1:0];
        pick_oh_d[i] = 1'b1;
        pick_cnt     = count[i*NBITS +: NBITS];
      end
    end
    // A zero count still gives one blink.
    rem_d = (pick_cnt == '0) ? REM_ONE : pick_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      last_q  <= LAST_RST;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req != '0) begin
            last_q  <= pick_idx_d;
            owner_q <= pick_oh_d;
            grant_q <= pick_oh_d;
            rem_q   <= rem_d;
            cnt_q   <= '0;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ON;
          end
        end
        S_ON: begin
          if (cnt_q == PH_LAST) begin
            cnt_q   <= '0;
            led_q   <= 1'b0;
            state_q <= S_OFF;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_OFF: begin
          if (cnt_q == PH_LAST) begin
            cnt_q <= '0;
            rem_q <= rem_q - REM_ONE;
            // rem_q == 1 here means the decremented value is zero.
            if (rem_q != REM_ONE) begin
              led_q   <= 1'b1;
              state_q <= S_ON;
            end else begin
`ifdef BLINK_ARB_GAP_EN
              state_q <= S_GAP;
`else
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              owner_q <= '0;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef BLINK_ARB_GAP_EN
        S_GAP: begin
          if (cnt_q == PH_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            owner_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign led   = led_q;
  assign done  = done_q;

endmodule
